// File: rtl/sum_collector.sv
// Captures the adder's sum on each rising edge of done into a first-word-fall-through FIFO.
// Optional running total of accepted sums is built when SUM_COLLECTOR_ACC_EN is defined.
module sum_collector #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               s,
    input  logic                     done,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [4:0]               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     acc_clear,
    output logic [ACC_W-1:0]         acc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Output handshake: a word transfers at an edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_data stays stable until taken.

    logic [4:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          done_q;
    logic          capture;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full;

    assign full    = (count == CW'(DEPTH));
    assign capture = done && !done_q;
    assign pop     = out_valid && out_ready;
    // A full FIFO still accepts a capture when the head leaves at the same edge.
    assign push    = capture && (!full || pop);
    assign drop    = capture && !push;

    assign out_valid = (count != '0);
    assign out_data  = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            done_q <= done;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (acc_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage has no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= s;
        end
    end

`ifdef SUM_COLLECTOR_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clear) begin
            acc <= push ? ACC_W'(s) : '0;
        end else if (push) begin
            acc <= acc + ACC_W'(s);
        end
    end
`else
    assign acc = '0;
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector: vector table for FIFO behaviour plus hand sequences
// for the accumulator, asynchronous reset and a behavioural adder with random back-pressure.
module tb_sum_collector;

    localparam int DEPTH = 4;
    localparam int ACC_W = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       s;
    logic             done;
    logic             out_ready;
    logic             out_valid;
    logic [4:0]       out_data;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             acc_clear;
    logic [ACC_W-1:0] acc;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q [$];

    typedef struct {
        logic          d;
        logic [4:0]    sv;
        logic          r;
        logic          c;
        int            reps;
        logic [CW-1:0] e_count;
        logic          e_valid;
        logic          e_chk_data;
        logic [4:0]    e_data;
        logic          e_ov;
    } vec_t;

    vec_t vecs [$];

    sum_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .done      (done),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .acc_clear (acc_clear),
        .acc       (acc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic d, input logic [4:0] sv, input logic r, input logic c);
        done      = d;
        s         = sv;
        out_ready = r;
        acc_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic d, input logic [4:0] sv, input logic r, input logic c,
                           input int reps, input logic [CW-1:0] e_count, input logic e_valid,
                           input logic e_chk_data, input logic [4:0] e_data, input logic e_ov);
        vec_t v;
        v.d = d; v.sv = sv; v.r = r; v.c = c; v.reps = reps;
        v.e_count = e_count; v.e_valid = e_valid; v.e_chk_data = e_chk_data;
        v.e_data = e_data; v.e_ov = e_ov;
        vecs.push_back(v);
    endtask

    function automatic logic [ACC_W-1:0] acc_exp(input logic [ACC_W-1:0] v);
`ifdef SUM_COLLECTOR_ACC_EN
        return v;
`else
        return '0;
`endif
    endfunction

    logic [3:0] op_a;
    logic [3:0] op_b;

    initial begin
        rst_n     = 1'b0;
        done      = 1'b0;
        s         = '0;
        out_ready = 1'b0;
        acc_clear = 1'b0;

        // single capture held high, then drain
        add_vec(1, 19, 0, 0, 10, 1, 1, 1, 19, 0);
        add_vec(0,  0, 1, 0,  1, 0, 0, 0,  0, 0);
        // fill with 3,7,30,0 then drop 12
        add_vec(1,  3, 0, 0, 1, 1, 1, 1, 3, 0);
        add_vec(0,  0, 0, 0, 1, 1, 1, 1, 3, 0);
        add_vec(1,  7, 0, 0, 1, 2, 1, 1, 3, 0);
        add_vec(0,  0, 0, 0, 1, 2, 1, 1, 3, 0);
        add_vec(1, 30, 0, 0, 1, 3, 1, 1, 3, 0);
        add_vec(0,  0, 0, 0, 1, 3, 1, 1, 3, 0);
        add_vec(1,  0, 0, 0, 1, 4, 1, 1, 3, 0);
        add_vec(0,  0, 0, 0, 1, 4, 1, 1, 3, 0);
        add_vec(1, 12, 0, 0, 1, 4, 1, 1, 3, 1);
        add_vec(0,  0, 0, 0, 1, 4, 1, 1, 3, 1);
        add_vec(0,  0, 1, 0, 1, 3, 1, 1, 7, 1);
        add_vec(0,  0, 1, 0, 1, 2, 1, 1, 30, 1);
        add_vec(0,  0, 1, 0, 1, 1, 1, 1, 0, 1);
        add_vec(0,  0, 1, 0, 1, 0, 0, 0, 0, 1);
        add_vec(0,  0, 0, 1, 1, 0, 0, 0, 0, 0);
        // full FIFO, push of 9 alongside a pop
        add_vec(1,  5, 0, 0, 1, 1, 1, 1, 5, 0);
        add_vec(0,  0, 0, 0, 1, 1, 1, 1, 5, 0);
        add_vec(1,  6, 0, 0, 1, 2, 1, 1, 5, 0);
        add_vec(0,  0, 0, 0, 1, 2, 1, 1, 5, 0);
        add_vec(1,  8, 0, 0, 1, 3, 1, 1, 5, 0);
        add_vec(0,  0, 0, 0, 1, 3, 1, 1, 5, 0);
        add_vec(1, 10, 0, 0, 1, 4, 1, 1, 5, 0);
        add_vec(0,  0, 0, 0, 1, 4, 1, 1, 5, 0);
        add_vec(1,  9, 1, 0, 1, 4, 1, 1, 6, 0);
        add_vec(0,  0, 1, 0, 1, 3, 1, 1, 8, 0);
        add_vec(0,  0, 1, 0, 1, 2, 1, 1, 10, 0);
        add_vec(0,  0, 1, 0, 1, 1, 1, 1, 9, 0);
        add_vec(0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
        // push and pop with a single entry held
        add_vec(1, 17, 0, 0, 1, 1, 1, 1, 17, 0);
        add_vec(0,  0, 0, 0, 1, 1, 1, 1, 17, 0);
        add_vec(1, 21, 1, 0, 1, 1, 1, 1, 21, 0);
        add_vec(0,  0, 1, 0, 1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", count, 0);
        chk("reset valid", out_valid, 0);
        chk("reset overflow", overflow, 0);
        chk("reset acc", acc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-release count", count, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                step(vecs[i].d, vecs[i].sv, vecs[i].r, vecs[i].c);
                chk($sformatf("v%0d.%0d count", i, k), count, vecs[i].e_count);
                chk($sformatf("v%0d.%0d valid", i, k), out_valid, vecs[i].e_valid);
                chk($sformatf("v%0d.%0d overflow", i, k), overflow, vecs[i].e_ov);
                if (vecs[i].e_chk_data) begin
                    chk($sformatf("v%0d.%0d data", i, k), out_data, vecs[i].e_data);
                end
            end
        end

        // running total: 31 + 2 wraps to 1, clear with capture of 5 gives 5
        step(0, 0, 1, 1);
        chk("acc after clear", acc, 0);
        step(1, 31, 1, 0);
        chk("acc 31", acc, acc_exp(31));
        step(0, 0, 1, 0);
        step(1, 2, 1, 0);
        chk("acc wrap", acc, acc_exp(1));
        step(0, 0, 1, 0);
        step(1, 5, 1, 1);
        chk("acc clear+push", acc, acc_exp(5));
        chk("acc clear+push count", count, 1);
        step(0, 0, 1, 0);
        chk("acc drained count", count, 0);

        // drop coinciding with clear: overflow set wins, total cleared without a push
        for (int v = 1; v <= 4; v++) begin
            step(1, 5'(v), 0, 0);
            step(0, 0, 0, 0);
        end
        chk("acc fill", acc, acc_exp(15));
        chk("fill count", count, 4);
        step(1, 7, 0, 1);
        chk("drop+clear overflow", overflow, 1);
        chk("drop+clear acc", acc, acc_exp(0));
        chk("drop+clear count", count, 4);
        step(0, 0, 1, 0);
        chk("three held count", count, 3);

        // asynchronous reset mid-cycle with three entries and overflow set
        done = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst count", count, 0);
        chk("async rst valid", out_valid, 0);
        chk("async rst overflow", overflow, 0);
        chk("async rst acc", acc, 0);
        done = 1'b1;
        s    = 13;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("done high at release count", count, 1);
        chk("done high at release data", out_data, 13);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            chk($sformatf("held after release %0d count", k), count, 1);
        end
        step(0, 0, 1, 0);
        chk("release drained", count, 0);

        // behavioural adder, one result per 3 cycles, random back-pressure
        begin
            int issued = 0;
            int gap = 0;
            int cyc = 0;
            logic d;
            logic [4:0] sv;
            logic r;
            logic pop_now;
            logic [4:0] data_now;
            exp_q.delete();
            while ((issued < 10 || exp_q.size() != 0) && cyc < 400) begin
                d  = 1'b0;
                sv = '0;
                if (gap == 0 && issued < 10 && count < CW'(DEPTH - 1)) begin
                    op_a = 4'($urandom_range(0, 15));
                    op_b = 4'($urandom_range(0, 15));
                    sv = 5'(op_a) + 5'(op_b);
                    d  = 1'b1;
                    exp_q.push_back(sv);
                    issued++;
                    gap = 2;
                end else if (gap > 0) begin
                    gap--;
                end
                r = ($urandom_range(0, 3) != 0);
                pop_now  = out_valid && r;
                data_now = out_data;
                step(d, sv, r, 0);
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL adder unexpected pop: got %0d expected none", data_now);
                    end else begin
                        chk($sformatf("adder data %0d", cyc), data_now, exp_q.pop_front());
                    end
                end
                cyc++;
            end
            chk("adder within budget", (cyc < 400), 1);
            chk("adder issued", issued, 10);
            chk("adder no drops", overflow, 0);
            chk("adder empty at end", count, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_collector.md
# sum_collector

Downstream consumer of the sample-and-add stage. Detects each rising edge of the adder's `done` level, captures the 5-bit sum `s` into a small first-word-fall-through FIFO, and presents the results on a valid/ready output port. Optionally keeps a wrapping running total of every captured sum. Sits between the adder and any result sink (bus master, checker, logger) that may stall.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `ACC_W`, default 12: running-total width in bits; ≥5.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock; all state updates on its posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s`  in  5  sum from the adder; valid in the cycle `done` first reads 1.
- `done`  in  1  adder completion level; may stay high for many cycles.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  5  head entry; holds its value while `out_valid && !out_ready`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one sum was dropped.
- `acc_clear`  in  1  synchronous clear of the running total and `overflow`.
- `acc`  out  ACC_W  running total (see Configuration).

## Operation
- `done_q` registers `done`. A capture event occurs at an edge where `done` = 1 and `done_q` = 0. A level held high never causes a second capture.
- On a capture event:
  - If `count < DEPTH`, or a pop occurs at the same edge, `s` is written at the tail.
  - Otherwise `s` is dropped and `overflow` is set.
- A pop occurs at an edge where `out_valid && out_ready`. The head advances.
- Push and pop at the same edge: both take effect and `count` is unchanged. This holds when full and when holding one entry. A simultaneous push into an empty FIFO with no pop gives `count` = 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate counter, so full and empty are unambiguous.
- `out_data` is read combinationally from the head entry. It is don't-care when `out_valid` = 0.
- `out_valid` = (`count` != 0).
- `acc_clear`:
  - Clears `overflow` at the edge.
  - If a drop occurs at the same edge, `overflow` ends at 1 (set wins).
- Reset values: `done_q` = 0, pointers = 0, `count` = 0, `out_valid` = 0, `overflow` = 0, `acc` = 0. Storage contents are undefined.
- Reset asserted mid-operation discards all entries immediately, asynchronously.
- After reset release, `done` already high (`done_q` = 0) counts as a rising edge and is captured once.

## Timing
- Capture latency: with the FIFO empty, `out_valid` = 1 and `out_data` = `s` are visible in the cycle after the capture edge (1 cycle).
- Throughput: one push and one pop per cycle maximum.
- `out_valid`, `count`, `overflow`, `acc` are registered. `out_data` is a mux of registered storage.
- `out_ready` has no combinational path to any output except through the next-cycle state.
- The upstream adder produces at most one result per 3 cycles. The block must nonetheless accept one capture per 2 cycles (`done` toggling), the fastest possible rising-edge rate.

## Configuration
- `SUM_COLLECTOR_ACC_EN` defined:
  - `acc` adds the zero-extended `s` on every accepted push (not on drops), modulo 2^ACC_W.
  - `acc_clear` zeroes `acc`. If clear and push happen at the same edge, `acc` = `s`.
- `SUM_COLLECTOR_ACC_EN` undefined:
  - No accumulator logic is built and `acc` is tied to 0.
  - `acc_clear` affects only `overflow`.

## Test plan
1. Reset, then `done` rises once with `s` = 19 and is held high for 10 cycles, `out_ready` = 0. Required: `count` = 1 one cycle after the edge and `out_data` = 19. No further capture occurs; `count` stays 1.
2. Four captures (3, 7, 30, 0) with `out_ready` = 0, then a fifth (12). Required: `count` = 4, 12 is dropped, `overflow` = 1. With `out_ready` = 1, outputs are 3, 7, 30, 0 in order, then `out_valid` = 0.
3. FIFO full, capture of 9 at the same edge as a pop. Required: `count` stays 4, `overflow` unchanged, and 9 emerges last.
4. `SUM_COLLECTOR_ACC_EN`, `ACC_W` = 5: captures 31 then 2. Required: `acc` = 1 (wrap). Then `acc_clear` at the same edge as capture 5 gives `acc` = 5.
5. `rst_n` pulsed low with 3 entries held. Required: `count` = 0, `out_valid` = 0 and `overflow` = 0 immediately, with no clock needed.
6. Random `out_ready` against the real adder for 10 random operand pairs. Required: every `out_data` equals a+b in issue order, with no drops.
